// File: rtl/outbound_link_arbiter_pkg.sv
// Shared definitions for the outbound link arbiter and the output buffers
// that feed it.
//   - arb_state_t : arbiter FSM state encoding (IDLE, GRANT, XFER)
//   - DEF_*       : default sizing constants used by the arbiter parameters
//   - ob_pkt_t    : packet image exchanged by the output buffers
package outbound_link_arbiter_pkg;

  localparam int DEF_NUM_PORTS     = 4;
  localparam int DEF_BYTES_PER_PKT = 4;
  localparam int DEF_TIMEOUT       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } arb_state_t;

  // Whole packet as held by an output buffer; byte 0 is sent first.
  typedef struct packed {
    logic [DEF_BYTES_PER_PKT-1:0][7:0] data;
  } ob_pkt_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin request picker, purely combinational.
// Ports:
//   req  [N]    : request vector
//   last [ID_W] : index granted most recently; search starts at last+1
//   idx  [ID_W] : first requesting index found, wrapping modulo N
//   any         : at least one request is set (idx valid)
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  logic [ID_W-1:0] probe;

  // NOTE: every output and temporary gets a default at the top of the block,
  // so no path leaves a value held and no latch is inferred.
  always_comb begin
    idx   = '0;
    any   = 1'b0;
    probe = last;
    for (int k = 0; k < N; k++) begin
      probe = (probe == ID_W'(N - 1)) ? '0 : probe + 1'b1;
      if (!any && req[probe]) begin
        any = 1'b1;
        idx = probe;
      end
    end
  end

endmodule

// File: rtl/outbound_link_arbiter.sv
// Shares one outbound byte link between NUM_PORTS output buffers.
// A waiting buffer is picked round-robin, pulsed with read_from_ob for one
// cycle, then its byte stream is forwarded until BYTES_PER_PKT bytes have
// passed or TIMEOUT consecutive silent cycles abort the transfer.
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   pkt_ready  [NUM_PORTS]  : buffer i holds a packet
//   payload_in [NUM_PORTS]x8, put_in [NUM_PORTS] : per-buffer byte streams
//   link_ready              : link can take a new packet
//   read_from_ob [NUM_PORTS]: one-hot start pulse to the granted buffer
//   payload_out [8], put_out: forwarded byte stream
//   grant_id                : current / last granted port
//   busy                    : transfer in progress (GRANT or XFER)
//   err_timeout             : sticky timeout-abort flag
//   pkt_count [NUM_PORTS]x16: completed packets per port (OUT_ARB_STATS_EN only)
// Optional feature macro: OUT_ARB_STATS_EN adds the pkt_count statistics port.
module outbound_link_arbiter
  import outbound_link_arbiter_pkg::*;
#(
  parameter int NUM_PORTS     = DEF_NUM_PORTS,
  parameter int BYTES_PER_PKT = DEF_BYTES_PER_PKT,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NUM_PORTS-1:0]            pkt_ready,
  input  logic [NUM_PORTS-1:0][7:0]       payload_in,
  input  logic [NUM_PORTS-1:0]            put_in,
  input  logic                            link_ready,
  output logic [NUM_PORTS-1:0]            read_from_ob,
  output logic [7:0]                      payload_out,
  output logic                            put_out,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
  output logic                            busy,
  output logic                            err_timeout
`ifdef OUT_ARB_STATS_EN
  ,
  output logic [NUM_PORTS-1:0][15:0]      pkt_count
`endif
);

  localparam int ID_W = $clog2(NUM_PORTS);
  localparam int BC_W = $clog2(BYTES_PER_PKT + 1);
  localparam int IC_W = $clog2(TIMEOUT + 1);

  arb_state_t      state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] pick_idx;
  logic            pick_any;
  logic [BC_W-1:0] byte_cnt;
  logic [IC_W-1:0] idle_cnt;
  logic            byte_seen;
  logic            pkt_done;
  logic            pkt_abort;

  rr_pick #(
    .N    (NUM_PORTS),
    .ID_W (ID_W)
  ) u_rr_pick (
    .req  (pkt_ready),
    .last (last_grant),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Only the granted buffer's strobe matters; the others are ignored.
  assign byte_seen = (state == XFER) && put_in[grant_id];
  // The byte that brings the count to BYTES_PER_PKT ends the packet.
  assign pkt_done  = byte_seen && (byte_cnt == BC_W'(BYTES_PER_PKT - 1));
  assign pkt_abort = (state == XFER) && !put_in[grant_id] &&
                     (idle_cnt == IC_W'(TIMEOUT - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      grant_id     <= '0;
      last_grant   <= ID_W'(NUM_PORTS - 1);
      byte_cnt     <= '0;
      idle_cnt     <= '0;
      read_from_ob <= '0;
      busy         <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (link_ready && pick_any) begin
            state        <= GRANT;
            grant_id     <= pick_idx;
            read_from_ob <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << pick_idx;
            busy         <= 1'b1;
          end
        end
        GRANT: begin
          state        <= XFER;
          read_from_ob <= '0;
          byte_cnt     <= '0;
          idle_cnt     <= '0;
        end
        XFER: begin
          if (byte_seen) begin
            byte_cnt <= byte_cnt + 1'b1;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
          if (pkt_abort) begin
            err_timeout <= 1'b1;
          end
          if (pkt_done || pkt_abort) begin
            state      <= IDLE;
            busy       <= 1'b0;
            last_grant <= grant_id;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Link side is a straight mux so the byte leaves in the cycle it arrives;
  // it also drops to zero the instant reset forces the state to IDLE.
  always_comb begin
    put_out     = 1'b0;
    payload_out = '0;
    if (state == XFER) begin
      put_out     = put_in[grant_id];
      payload_out = payload_in[grant_id];
    end
  end

`ifdef OUT_ARB_STATS_EN
  // NOTE: the counter array is a small flop bank, not a RAM, so it is reset
  // as a whole; a RAM-backed version would have to be cleared by a walk.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= '0;
    end else if (pkt_done && (pkt_count[grant_id] != 16'hFFFF)) begin
      pkt_count[grant_id] <= pkt_count[grant_id] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_outbound_link_arbiter.sv
// Self-checking bench for outbound_link_arbiter (default 4 ports, 4 bytes,
// timeout 8): directed vector table, multi-cycle corner sequences and a
// randomized run against a transaction-level reference model.
module tb_outbound_link_arbiter;

  localparam int N   = 4;
  localparam int BPP = 4;
  localparam int TO  = 8;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [N-1:0]     pkt_ready;
  logic [N-1:0][7:0] payload_in;
  logic [N-1:0]     put_in;
  logic             link_ready;
  logic [N-1:0]     read_from_ob;
  logic [7:0]       payload_out;
  logic             put_out;
  logic [1:0]       grant_id;
  logic             busy;
  logic             err_timeout;
`ifdef OUT_ARB_STATS_EN
  logic [N-1:0][15:0] pkt_count;
`endif

  int errors = 0;
  int checks = 0;

  outbound_link_arbiter #(
    .NUM_PORTS     (N),
    .BYTES_PER_PKT (BPP),
    .TIMEOUT       (TO)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pkt_ready    (pkt_ready),
    .payload_in   (payload_in),
    .put_in       (put_in),
    .link_ready   (link_ready),
    .read_from_ob (read_from_ob),
    .payload_out  (payload_out),
    .put_out      (put_out),
    .grant_id     (grant_id),
    .busy         (busy),
    .err_timeout  (err_timeout)
`ifdef OUT_ARB_STATS_EN
    ,
    .pkt_count    (pkt_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]      pr;
    logic            lr;
    logic [3:0]      put;
    logic [3:0][7:0] pay;
    logic [3:0]      e_read;
    logic            e_put;
    logic [7:0]      e_pay;
    logic [1:0]      e_gid;
    logic            e_busy;
  } vec_t;

  vec_t vq[$];

  // Reference model state: stage 0 waiting, 1 start pulse, 2 streaming.
  int   ms, mg, ml, mb, mq;
  bit   merr;
  bit   found;
  int   rate;
  int   ngrant, last_t;
  logic [3:0] exp_read;
  logic       exp_put;
  logic [7:0] exp_pay;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    pkt_ready  = '0;
    link_ready = 1'b0;
    put_in     = '0;
    payload_in = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  function automatic vec_t mk(logic [3:0] pr, logic lr, logic [3:0] put, logic [7:0] b0,
                              logic [7:0] b1, logic [7:0] b2, logic [3:0] er, logic ep,
                              logic [7:0] epay, logic [1:0] eg, logic eb);
    vec_t v;
    v.pr = pr; v.lr = lr; v.put = put;
    v.pay = {8'h3C, b2, b1, b0};
    v.e_read = er; v.e_put = ep; v.e_pay = epay; v.e_gid = eg; v.e_busy = eb;
    return v;
  endfunction

  initial begin
    // ---------------- vector table ----------------
    // Single packet on port 0 (bytes A1..A4), with a stray port-1 strobe.
    vq.push_back(mk(4'b0001, 1, 4'b0000, 8'h00, 8'h00, 8'h00, 4'b0000, 0, 8'h00, 2'd0, 0));
    vq.push_back(mk(4'b0000, 1, 4'b0000, 8'h00, 8'h00, 8'h00, 4'b0001, 0, 8'h00, 2'd0, 1));
    vq.push_back(mk(4'b0000, 1, 4'b0011, 8'hA1, 8'h55, 8'h00, 4'b0000, 1, 8'hA1, 2'd0, 1));
    vq.push_back(mk(4'b0000, 1, 4'b0001, 8'hA2, 8'h55, 8'h00, 4'b0000, 1, 8'hA2, 2'd0, 1));
    vq.push_back(mk(4'b1111, 1, 4'b0001, 8'hA3, 8'h00, 8'h00, 4'b0000, 1, 8'hA3, 2'd0, 1));
    vq.push_back(mk(4'b1111, 0, 4'b0001, 8'hA4, 8'h00, 8'h00, 4'b0000, 1, 8'hA4, 2'd0, 1));
    vq.push_back(mk(4'b0000, 1, 4'b0001, 8'h77, 8'h00, 8'h00, 4'b0000, 0, 8'h00, 2'd0, 0));
    // Port 2 waits while the link is not ready, then is granted.
    for (int i = 0; i < 10; i++)
      vq.push_back(mk(4'b0100, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 4'b0000, 0, 8'h00, 2'd0, 0));
    vq.push_back(mk(4'b0100, 1, 4'b0000, 8'h00, 8'h00, 8'h00, 4'b0000, 0, 8'h00, 2'd0, 0));
    vq.push_back(mk(4'b0000, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 4'b0100, 0, 8'h00, 2'd2, 1));
    vq.push_back(mk(4'b0000, 0, 4'b0100, 8'h00, 8'h00, 8'hB1, 4'b0000, 1, 8'hB1, 2'd2, 1));
    vq.push_back(mk(4'b0000, 0, 4'b0101, 8'h99, 8'h00, 8'hB2, 4'b0000, 1, 8'hB2, 2'd2, 1));
    vq.push_back(mk(4'b0000, 0, 4'b0100, 8'h00, 8'h00, 8'hB3, 4'b0000, 1, 8'hB3, 2'd2, 1));
    vq.push_back(mk(4'b0000, 0, 4'b0100, 8'h00, 8'h00, 8'hB4, 4'b0000, 1, 8'hB4, 2'd2, 1));
    vq.push_back(mk(4'b0000, 0, 4'b0000, 8'h00, 8'h00, 8'h00, 4'b0000, 0, 8'h00, 2'd2, 0));

    // ---------------- reset values ----------------
    reset_n = 1'b0;
    idle_inputs();
    tick();
    #1;
    check("rst_read", read_from_ob, 4'b0000);
    check("rst_put", put_out, 1'b0);
    check("rst_payload", payload_out, 8'h00);
    check("rst_gid", grant_id, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    reset_n = 1'b1;

    foreach (vq[i]) begin
      pkt_ready = vq[i].pr; link_ready = vq[i].lr;
      put_in = vq[i].put; payload_in = vq[i].pay;
      #1;
      check($sformatf("vec%0d_read", i), read_from_ob, vq[i].e_read);
      check($sformatf("vec%0d_put", i), put_out, vq[i].e_put);
      check($sformatf("vec%0d_payload", i), payload_out, vq[i].e_pay);
      check($sformatf("vec%0d_gid", i), grant_id, vq[i].e_gid);
      check($sformatf("vec%0d_busy", i), busy, vq[i].e_busy);
      check($sformatf("vec%0d_err", i), err_timeout, 1'b0);
      tick();
    end

    // ---------------- strict rotation with all ports requesting ----------------
    do_reset();
    pkt_ready = 4'b1111; link_ready = 1'b1; put_in = 4'b1111;
    payload_in = {8'h44, 8'h33, 8'h22, 8'h11};
    ngrant = 0; last_t = -1;
    for (int c = 0; c < 60 && ngrant < 4; c++) begin
      #1;
      if (read_from_ob != 4'b0000) begin
        check("rot_read", read_from_ob, 4'b0001 << ngrant);
        check("rot_gid", grant_id, ngrant);
        if (last_t >= 0) check("rot_spacing", c - last_t, BPP + 2);
        last_t = c;
        ngrant++;
      end
      tick();
    end
    check("rot_count", ngrant, 4);

    // ---------------- timeout abort on port 1 ----------------
    do_reset();
    pkt_ready = 4'b0010; link_ready = 1'b1;
    tick();
    #1;
    check("to_grant_read", read_from_ob, 4'b0010);
    check("to_grant_gid", grant_id, 2'd1);
    pkt_ready = 4'b0110;
    put_in = 4'b0010; payload_in[1] = 8'hD1;
    tick();
    tick();
    payload_in[1] = 8'hD2;
    tick();
    put_in = 4'b0000;
    for (int i = 0; i < TO - 1; i++) tick();
    #1;
    check("to_err_early", err_timeout, 1'b0);
    check("to_busy_early", busy, 1'b1);
    tick();
    #1;
    check("to_err_set", err_timeout, 1'b1);
    check("to_busy_clear", busy, 1'b0);
    tick();
    #1;
    check("to_next_read", read_from_ob, 4'b0100);
    check("to_next_gid", grant_id, 2'd2);
    check("to_err_sticky", err_timeout, 1'b1);

    // ---------------- reset during byte 2 ----------------
    pkt_ready = 4'b0000; put_in = 4'b0100; payload_in[2] = 8'hC1;
    tick();
    #1;
    check("mid_byte1_put", put_out, 1'b1);
    check("mid_byte1_payload", payload_out, 8'hC1);
    payload_in[2] = 8'hC2;
    tick();
    #1;
    check("mid_byte2_payload", payload_out, 8'hC2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_put", put_out, 1'b0);
    check("mid_rst_payload", payload_out, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_read", read_from_ob, 4'b0000);
    check("mid_rst_gid", grant_id, 2'd0);
    check("mid_rst_err", err_timeout, 1'b0);
`ifdef OUT_ARB_STATS_EN
    for (int p = 0; p < N; p++) check($sformatf("mid_rst_cnt%0d", p), pkt_count[p], 16'd0);
`endif
    tick();
    tick();
    #1;
    check("mid_hold_put", put_out, 1'b0);
    reset_n = 1'b1;

`ifdef OUT_ARB_STATS_EN
    // ---------------- statistics: three packets on port 3 ----------------
    do_reset();
    pkt_ready = 4'b1000; link_ready = 1'b1; put_in = 4'b1000;
    ngrant = 0;
    for (int c = 0; c < 80 && (ngrant < 3 || busy); c++) begin
      #1;
      if (read_from_ob != 4'b0000) ngrant++;
      if (ngrant == 3) pkt_ready = 4'b0000;
      tick();
    end
    #1;
    check("stats_grants", ngrant, 3);
    check("stats_port3", pkt_count[3], 16'd3);
    for (int p = 0; p < 3; p++) check($sformatf("stats_port%0d", p), pkt_count[p], 16'd0);
`endif

    // ---------------- randomized run against reference model ----------------
    do_reset();
    ms = 0; mg = 0; ml = N - 1; mb = 0; mq = 0; merr = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rate = (((c / 40) % 3) == 2) ? 5 : 80;
      pkt_ready  = 4'($urandom_range(0, 15));
      link_ready = ($urandom_range(0, 9) < 8);
      for (int p = 0; p < N; p++) begin
        put_in[p]     = ($urandom_range(0, 99) < rate);
        payload_in[p] = 8'($urandom);
      end
      #1;
      exp_read = (ms == 1) ? (4'b0001 << mg) : 4'b0000;
      exp_put  = (ms == 2) ? put_in[mg] : 1'b0;
      exp_pay  = (ms == 2) ? payload_in[mg] : 8'h00;
      check("rnd_read", read_from_ob, exp_read);
      check("rnd_put", put_out, exp_put);
      check("rnd_payload", payload_out, exp_pay);
      check("rnd_gid", grant_id, mg);
      check("rnd_busy", busy, ms != 0);
      check("rnd_err", err_timeout, merr);
      tick();
      // Advance the model by one clock using the inputs just applied.
      case (ms)
        0: begin
          if (link_ready && pkt_ready != 4'b0000) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
              if (!found && pkt_ready[(ml + k) % N]) begin
                mg = (ml + k) % N;
                found = 1'b1;
              end
            end
            ms = 1;
          end
        end
        1: begin
          ms = 2; mb = 0; mq = 0;
        end
        default: begin
          if (put_in[mg]) begin
            mb++; mq = 0;
            if (mb == BPP) begin ms = 0; ml = mg; end
          end else begin
            mq++;
            if (mq == TO) begin merr = 1'b1; ms = 0; ml = mg; end
          end
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/outbound_link_arbiter.md
OUTBOUND_LINK_ARBITER -- requirements
Module: outbound_link_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of output buffers sharing one outbound link.
REQ-002 Parameter BYTES_PER_PKT, default 4: bytes serialized per packet.
REQ-003 Parameter TIMEOUT, default 8: max cycles in XFER without a byte before abort.
REQ-004 clock  input  1  sole clock; all state updates on posedge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 pkt_ready  input  NUM_PORTS  bit i: buffer i holds a packet awaiting read_from_ob.
REQ-007 payload_in  input  NUM_PORTS x 8  byte stream from each buffer.
REQ-008 put_in  input  NUM_PORTS  bit i: payload_in[i] valid this cycle.
REQ-009 link_ready  input  1  downstream link can accept a new packet.
REQ-010 read_from_ob  output  NUM_PORTS  one-hot start pulse to the granted buffer.
REQ-011 payload_out  output  8  byte forwarded to the shared link.
REQ-012 put_out  output  1  payload_out valid.
REQ-013 grant_id  output  $clog2(NUM_PORTS)  index of current/last granted port.
REQ-014 busy  output  1  high in GRANT or XFER.
REQ-015 err_timeout  output  1  sticky; set when an XFER aborts on timeout.

Function
REQ-016 FSM states IDLE, GRANT, XFER, encoded in a shared enum.
REQ-017 IDLE -> GRANT when link_ready=1 and |pkt_ready; else stay IDLE.
REQ-018 On IDLE->GRANT, grant_id registers the first set pkt_ready bit searching from (last_grant+1) mod NUM_PORTS upward, wrapping.
REQ-019 GRANT lasts exactly one cycle; read_from_ob[grant_id]=1 only in GRANT; GRANT -> XFER unconditionally.
REQ-020 In XFER, payload_out=payload_in[grant_id] and put_out=put_in[grant_id] combinationally; non-granted put_in/payload_in ignored (put_out=0, payload_out=0 outside XFER).
REQ-021 Byte counter (width $clog2(BYTES_PER_PKT+1)) increments per cycle with put_in[grant_id]=1 in XFER; clears on entry to XFER.
REQ-022 When counter reaches BYTES_PER_PKT: XFER -> IDLE, last_grant <= grant_id.
REQ-023 Idle counter counts consecutive XFER cycles with put_in[grant_id]=0; reaching TIMEOUT sets err_timeout, XFER -> IDLE, last_grant <= grant_id.
REQ-024 Expected latency: grant pulse at cycle T, first byte at T+1, last at T+BYTES_PER_PKT, IDLE at T+BYTES_PER_PKT+1, earliest next GRANT at T+BYTES_PER_PKT+2.
REQ-025 pkt_ready and link_ready changes during GRANT/XFER have no effect on the current transfer.
REQ-026 Single requester repeatedly requesting is granted every packet; all requesting: strict rotation 0,1,2,3,0...
REQ-027 err_timeout clears only on reset.

Reset
REQ-028 reset_n low asynchronously forces: state IDLE, read_from_ob=0, put_out=0, payload_out=0, grant_id=0, last_grant=NUM_PORTS-1, counters=0, busy=0, err_timeout=0.
REQ-029 Reset mid-XFER abandons the packet; no byte forwarded after reset assertion.

Configuration
REQ-030 Macro OUT_ARB_STATS_EN defined: add output pkt_count (NUM_PORTS x 16), per-port count of packets completed per REQ-022, saturating at 16'hFFFF, reset 0; timeout aborts not counted.
REQ-031 Macro undefined: pkt_count port and logic absent; all other behaviour identical.

Structure
REQ-032 Shared package holds the FSM state enum and default NUM_PORTS/BYTES_PER_PKT constants; the packet type already shared by the buffers stays in that package.
REQ-033 Round-robin pointer search is one sub-module rr_pick (inputs req, last; output idx, any), purely combinational.

Verification
REQ-034 Reset, then pkt_ready=4'b0001, link_ready=1 -> read_from_ob=4'b0001 one cycle, bytes A1,A2,A3,A4 on payload_out with put_out high 4 cycles, back to IDLE.
REQ-035 pkt_ready=4'b1111 held for 4 packets -> grant_id sequence 0,1,2,3; no two grants overlap.
REQ-036 link_ready=0 with pkt_ready=4'b0100 for 10 cycles -> no read_from_ob; link_ready=1 -> grant to port 2 next cycle.
REQ-037 Grant port 1, drive only 2 bytes then silence -> after 8 idle cycles err_timeout=1, FSM IDLE, next grant to port 2 if requesting.
REQ-038 Assert reset_n=0 during byte 2 of XFER -> put_out=0 immediately, all outputs at reset values; with OUT_ARB_STATS_EN, pkt_count unchanged from 0.
REQ-039 OUT_ARB_STATS_EN, 3 packets on port 3 -> pkt_count[3]=3, others 0.
